// File: rtl/cobra1_pkg.sv
// Shared VRAM definitions for the cobra1 video subsystem.
// Holds the VRAM geometry, the access tag and the CPU-side FSM states.
package cobra1_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VGA,
    TAG_CPU
  } tag_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_ACK
  } cpu_st_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the VGA fetcher and the CPU.
// VGA normally wins; a starvation counter forces a CPU slot.
module vram_arbiter
  import cobra1_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic               clk_pxl,
  input  logic               rst_n,
  input  logic               vga_req,
  input  logic [VRAM_AW-1:0] vga_a,
  output logic               vga_grant,
  output logic               vga_valid,
  output logic [VRAM_DW-1:0] vga_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_a,
  input  logic [VRAM_DW-1:0] cpu_wd,
  output logic               cpu_ack,
  output logic [VRAM_DW-1:0] cpu_rd,
  output logic [VRAM_AW-1:0] ram_a,
  output logic [VRAM_DW-1:0] ram_do,
  output logic               ram_w,
  input  logic [VRAM_DW-1:0] ram_di
);

  localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

  cpu_st_e    r_state;
  cpu_st_e    w_nstate;
  tag_e       r_tag1;
  tag_e       r_tag2;
  tag_e       w_tag;
  logic [3:0] r_starve;
  logic       r_cpu_we;
  logic       w_cpu_rdy;
  logic       w_force;
  logic       w_vga_iss;
  logic       w_cpu_iss;

  assign cpu_ack = (r_state == C_ACK);

  // Pick this edge's winner and the CPU FSM next state.
  always_comb begin
    w_cpu_rdy = (r_state == C_IDLE) && cpu_req;
    w_force   = w_cpu_rdy && (r_starve >= LP_SMAX);
    w_vga_iss = vga_req && !w_force;
    w_cpu_iss = w_cpu_rdy && !w_vga_iss;
    w_tag     = TAG_NONE;
    if (w_vga_iss) begin
      w_tag = TAG_VGA;
    end else if (w_cpu_iss) begin
      w_tag = TAG_CPU;
    end
    w_nstate = r_state;
    unique case (r_state)
      C_IDLE:  if (w_cpu_iss) w_nstate = C_WAIT;
      C_WAIT:  if (r_tag2 == TAG_CPU) w_nstate = C_ACK;
      C_ACK:   if (!cpu_req) w_nstate = C_IDLE;
      default: w_nstate = C_IDLE;
    endcase
  end

  // CPU FSM state register.
  always_ff @(posedge clk_pxl or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_nstate;
  end

  // Register the issued access and push its tag down the pipe.
  always_ff @(posedge clk_pxl or negedge rst_n) begin
    if (!rst_n) begin
      ram_a     <= '0;
      ram_do    <= '0;
      ram_w     <= 1'b0;
      vga_grant <= 1'b0;
      r_cpu_we  <= 1'b0;
      r_tag1    <= TAG_NONE;
      r_tag2    <= TAG_NONE;
    end else begin
      ram_w     <= w_cpu_iss && cpu_we;
      vga_grant <= w_vga_iss;
      r_tag1    <= w_tag;
      r_tag2    <= r_tag1;
      if (w_vga_iss) begin
        ram_a <= vga_a;
      end else if (w_cpu_iss) begin
        ram_a    <= cpu_a;
        ram_do   <= cpu_wd;
        r_cpu_we <= cpu_we;
      end
    end
  end

  // Route returning RAM data to its owner as the tag retires.
  always_ff @(posedge clk_pxl or negedge rst_n) begin
    if (!rst_n) begin
      vga_valid <= 1'b0;
      vga_rdata <= '0;
      cpu_rd    <= '0;
    end else begin
      vga_valid <= (r_tag2 == TAG_VGA);
      if (r_tag2 == TAG_VGA) vga_rdata <= ram_di;
      if (r_tag2 == TAG_CPU && !r_cpu_we) cpu_rd <= ram_di;
    end
  end

  // Count VGA wins while an idle CPU request waits.
  always_ff @(posedge clk_pxl or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_cpu_iss || (r_state == C_IDLE && !cpu_req)) begin
      r_starve <= '0;
    end else if (w_vga_iss && w_cpu_rdy && r_starve != 4'hF) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter.
// Expected values come from a queue-based access model.
module tb_vram_arbiter;

  localparam int SMAX   = 8;
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_ACK  = 2;

  logic        clk_pxl = 1'b0;
  logic        rst_n;
  logic        vga_req, cpu_req, cpu_we;
  logic [10:0] vga_a, cpu_a, ram_a;
  logic [7:0]  cpu_wd, vga_rdata, cpu_rd, ram_do, ram_di;
  logic        vga_grant, vga_valid, cpu_ack, ram_w;

  logic        d0_vga_req, d0_cpu_req, d0_cpu_we;
  logic [10:0] d0_vga_a, d0_cpu_a, d0_ram_a;
  logic [7:0]  d0_cpu_wd, d0_vga_rdata, d0_cpu_rd, d0_ram_do, d0_ram_di;
  logic        d0_vga_grant, d0_vga_valid, d0_cpu_ack, d0_ram_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_pxl = ~clk_pxl;

  function automatic logic [7:0] init_val(input logic [10:0] a);
    if (a == 11'h123) return 8'hA5;
    return a[7:0] ^ {a[10:8], 5'h15};
  endfunction

  vram_arbiter #(.STARVE_MAX(SMAX)) u_dut (
    .clk_pxl(clk_pxl), .rst_n(rst_n),
    .vga_req(vga_req), .vga_a(vga_a), .vga_grant(vga_grant),
    .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_ack(cpu_ack), .cpu_rd(cpu_rd),
    .ram_a(ram_a), .ram_do(ram_do), .ram_w(ram_w), .ram_di(ram_di)
  );

  vram_arbiter #(.STARVE_MAX(0)) u_dut0 (
    .clk_pxl(clk_pxl), .rst_n(rst_n),
    .vga_req(d0_vga_req), .vga_a(d0_vga_a), .vga_grant(d0_vga_grant),
    .vga_valid(d0_vga_valid), .vga_rdata(d0_vga_rdata),
    .cpu_req(d0_cpu_req), .cpu_we(d0_cpu_we), .cpu_a(d0_cpu_a),
    .cpu_wd(d0_cpu_wd), .cpu_ack(d0_cpu_ack), .cpu_rd(d0_cpu_rd),
    .ram_a(d0_ram_a), .ram_do(d0_ram_do), .ram_w(d0_ram_w),
    .ram_di(d0_ram_di)
  );

  logic [7:0]  mem [2048];
  bit   [2047:0] wrt;

  always @(posedge clk_pxl) begin
    if (ram_w) begin
      mem[ram_a] <= ram_do;
      wrt[ram_a] <= 1'b1;
    end
    ram_di <= wrt[ram_a] ? mem[ram_a] : init_val(ram_a);
    d0_ram_di <= init_val(d0_ram_a);
  end

  typedef struct {
    int         due;
    bit         vga;
    bit         we;
    logic [7:0] d;
  } acc_t;

  acc_t        q[$];
  logic [7:0]  mmem [2048];
  int          cyc;
  int          m_phase;
  int          m_starve;
  bit          wr_pend;
  logic [10:0] wr_a;
  logic [7:0]  wr_d;
  bit          e_grant, e_valid, e_ramw, e_iss, e_ack;
  logic [10:0] e_ram_a;
  logic [7:0]  e_ram_do, e_vrd, e_cpurd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_pend  = 0;
    m_phase  = P_IDLE;
    m_starve = 0;
    e_grant  = 0;
    e_valid  = 0;
    e_ramw   = 0;
    e_iss    = 0;
    e_ack    = 0;
    e_ram_a  = '0;
    e_ram_do = '0;
    e_vrd    = '0;
    e_cpurd  = '0;
  endtask

  // What happens at the coming edge, from the current inputs.
  task automatic model_step();
    bit cpu_done, can, starved, vi, ci;
    int pre;
    cyc++;
    if (wr_pend) mmem[wr_a] = wr_d;
    wr_pend  = 0;
    e_grant  = 0;
    e_valid  = 0;
    e_ramw   = 0;
    e_iss    = 0;
    cpu_done = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      acc_t a;
      a = q.pop_front();
      if (a.vga) begin
        e_valid = 1;
        e_vrd   = a.d;
      end else begin
        cpu_done = 1;
        if (!a.we) e_cpurd = a.d;
      end
    end
    pre     = m_phase;
    can     = (pre == P_IDLE) && cpu_req;
    starved = can && (m_starve >= SMAX);
    vi      = !starved && vga_req;
    ci      = can && !vi;
    if (vi) begin
      e_grant = 1;
      e_iss   = 1;
      e_ram_a = vga_a;
      q.push_back('{cyc + 2, 1'b1, 1'b0, mmem[vga_a]});
      if (can && m_starve < 15) m_starve++;
    end else if (ci) begin
      e_iss   = 1;
      e_ram_a = cpu_a;
      q.push_back('{cyc + 2, 1'b0, cpu_we, mmem[cpu_a]});
      if (cpu_we) begin
        e_ramw   = 1;
        e_ram_do = cpu_wd;
        wr_pend  = 1;
        wr_a     = cpu_a;
        wr_d     = cpu_wd;
      end
      m_starve = 0;
      m_phase  = P_WAIT;
    end
    if (pre == P_IDLE && !cpu_req) m_starve = 0;
    if (pre == P_WAIT && cpu_done) m_phase = P_ACK;
    if (pre == P_ACK && !cpu_req) m_phase = P_IDLE;
    e_ack = (m_phase == P_ACK);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_pxl);
    #1;
    chk("grant", 32'(vga_grant), 32'(e_grant));
    chk("valid", 32'(vga_valid), 32'(e_valid));
    if (e_valid) chk("vga_rdata", 32'(vga_rdata), 32'(e_vrd));
    chk("ram_w", 32'(ram_w), 32'(e_ramw));
    if (e_iss) chk("ram_a", 32'(ram_a), 32'(e_ram_a));
    if (e_ramw) chk("ram_do", 32'(ram_do), 32'(e_ram_do));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    if (e_ack) chk("cpu_rd", 32'(cpu_rd), 32'(e_cpurd));
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      if (cpu_ack) break;
      tick();
    end
    chk("ack_seen", 32'(cpu_ack), 32'd1);
  endtask

  function automatic logic [10:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 11'h7FF;
    return 11'($urandom_range(0, 31));
  endfunction

  initial begin
    int n_gr, n_w;
    for (int i = 0; i < 2048; i++) mmem[i] = init_val(11'(i));
    cyc = 0;
    model_reset();
    rst_n = 1'b0;
    {vga_req, cpu_req, cpu_we} = '0;
    vga_a = '0; cpu_a = '0; cpu_wd = '0;
    {d0_vga_req, d0_cpu_req, d0_cpu_we} = '0;
    d0_vga_a = '0; d0_cpu_a = '0; d0_cpu_wd = '0;
    #1;
    chk("rst_ram_w", 32'(ram_w), 32'd0);
    chk("rst_ram_a", 32'(ram_a), 32'd0);
    chk("rst_ram_do", 32'(ram_do), 32'd0);
    chk("rst_grant", 32'(vga_grant), 32'd0);
    chk("rst_valid", 32'(vga_valid), 32'd0);
    chk("rst_vrdata", 32'(vga_rdata), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rd", 32'(cpu_rd), 32'd0);
    repeat (2) @(posedge clk_pxl);
    @(negedge clk_pxl);
    rst_n = 1'b1;

    // Strict CPU priority on simultaneous first requests.
    d0_vga_req = 1; d0_vga_a = 11'h0AB;
    d0_cpu_req = 1; d0_cpu_we = 1; d0_cpu_a = 11'h055; d0_cpu_wd = 8'h3C;
    tick();
    chk("p0_ram_w", 32'(d0_ram_w), 32'd1);
    chk("p0_ram_a", 32'(d0_ram_a), 32'h055);
    chk("p0_ram_do", 32'(d0_ram_do), 32'h3C);
    chk("p0_grant", 32'(d0_vga_grant), 32'd0);
    tick();
    chk("p0_grant2", 32'(d0_vga_grant), 32'd1);
    chk("p0_ram_w2", 32'(d0_ram_w), 32'd0);
    d0_vga_req = 0;
    tick();
    chk("p0_ack", 32'(d0_cpu_ack), 32'd1);
    chk("p0_cpu_rd", 32'(d0_cpu_rd), 32'd0);
    d0_cpu_req = 0;
    tick();
    chk("p0_valid", 32'(d0_vga_valid), 32'd1);
    chk("p0_vrdata", 32'(d0_vga_rdata), 32'(init_val(11'h0AB)));
    chk("p0_ack_off", 32'(d0_cpu_ack), 32'd0);

    // VGA read of a preloaded word.
    vga_req = 1; vga_a = 11'h123;
    tick();
    chk("v_grant", 32'(vga_grant), 32'd1);
    vga_req = 0;
    tick();
    chk("v_valid_early", 32'(vga_valid), 32'd0);
    tick();
    chk("v_valid", 32'(vga_valid), 32'd1);
    chk("v_rdata", 32'(vga_rdata), 32'hA5);

    // CPU write then read back of the top word.
    cpu_req = 1; cpu_we = 1; cpu_a = 11'h7FF; cpu_wd = 8'h5A;
    n_w = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_w += int'(ram_w);
      if (cpu_ack) break;
    end
    chk("wr_pulses", 32'(n_w), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_ack_hold", 32'(cpu_ack), 32'd1);
    end
    cpu_req = 0;
    tick();
    chk("wr_ack_drop", 32'(cpu_ack), 32'd0);
    cpu_req = 1; cpu_we = 0;
    wait_ack();
    for (int i = 0; i < 3; i++) begin
      chk("rd_7ff", 32'(cpu_rd), 32'h5A);
      tick();
    end
    cpu_req = 0;
    tick();

    // Starvation override with VGA asking every cycle.
    tick();
    vga_req = 1; vga_a = 11'h010;
    cpu_req = 1; cpu_we = 0; cpu_a = 11'h011;
    n_gr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!vga_grant) break;
      n_gr++;
      vga_a = 11'($urandom_range(0, 31));
    end
    chk("starve_grants", 32'(n_gr), 32'(SMAX));
    tick();
    chk("vga_resume", 32'(vga_grant), 32'd1);
    vga_req = 0;
    wait_ack();
    cpu_req = 0;
    tick();

    // VGA every cycle while a CPU read is outstanding.
    cpu_req = 1; cpu_we = 0; cpu_a = 11'h040;
    tick();
    vga_req = 1;
    for (int i = 0; i < 4; i++) begin
      vga_a = 11'h100 + 11'(i);
      tick();
    end
    vga_req = 0;
    wait_ack();
    chk("il_cpu_rd", 32'(cpu_rd), 32'(init_val(11'h040)));
    cpu_req = 0;
    repeat (3) tick();

    // Reset right after a CPU write issue with a VGA read in flight.
    vga_req = 1; vga_a = 11'h200;
    cpu_req = 1; cpu_we = 1; cpu_a = 11'h201; cpu_wd = 8'hEE;
    tick();
    vga_req = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_w", 32'(ram_w), 32'd0);
    chk("mid_rst_grant", 32'(vga_grant), 32'd0);
    model_reset();
    cpu_req = 0;
    @(negedge clk_pxl);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", 32'(vga_valid), 32'd0);
      chk("post_rst_ack", 32'(cpu_ack), 32'd0);
    end
    vga_req = 1; vga_a = 11'h201;
    tick();
    vga_req = 0;
    repeat (3) tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (!vga_req || e_grant) begin
        vga_req = ($urandom_range(0, 9) < 6);
        vga_a   = rnd_addr();
      end
      if (cpu_req) begin
        if (m_phase == P_ACK) begin
          if ($urandom_range(0, 1) == 1) cpu_req = 0;
        end else if (m_phase == P_IDLE) begin
          if ($urandom_range(0, 19) == 0) cpu_req = 0;
        end else if ($urandom_range(0, 9) == 0) begin
          cpu_req = 0;
        end
      end else if (m_phase == P_IDLE && $urandom_range(0, 3) == 0) begin
        cpu_req = 1;
        cpu_we  = 1'($urandom_range(0, 1));
        cpu_a   = rnd_addr();
        cpu_wd  = 8'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
